// File: rtl/qspi_resp_pkg.sv
// Shared types and constants for the QSPI PSRAM responder.
// States, command bytes and field sizes used by the frame decoder.
package qspi_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        READ,
        WRITE,
        IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'hEB;
    localparam logic [7:0] CMD_WRITE = 8'h38;
    localparam int ADDR_NIBS = 6;
    localparam int CNT_W     = 4;

endpackage

// File: rtl/qspi_resp_sync.sv
// Two-flop synchronizers for the QSPI pins plus sclk edge detection.
// Clock, CS and data all see the same two-cycle delay.
module qspi_resp_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       qspi_clk_in,
    input  logic       qspi_cs_n_in,
    input  logic [3:0] qspi_data_in,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic       cs_n_s,
    output logic [3:0] data_s
);

    logic       r_clk_m;
    logic       r_clk_s;
    logic       r_clk_d;
    logic       r_cs_m;
    logic       r_cs_s;
    logic [3:0] r_dat_m;
    logic [3:0] r_dat_s;

    // CS resets to "selected" so a frame already in flight at reset
    // release never looks like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk_m <= 1'b0;
            r_clk_s <= 1'b0;
            r_clk_d <= 1'b0;
            r_cs_m  <= 1'b0;
            r_cs_s  <= 1'b0;
            r_dat_m <= 4'h0;
            r_dat_s <= 4'h0;
        end else begin
            r_clk_m <= qspi_clk_in;
            r_clk_s <= r_clk_m;
            r_clk_d <= r_clk_s;
            r_cs_m  <= qspi_cs_n_in;
            r_cs_s  <= r_cs_m;
            r_dat_m <= qspi_data_in;
            r_dat_s <= r_dat_m;
        end
    end

    assign sclk_rise = r_clk_s & ~r_clk_d;
    assign sclk_fall = ~r_clk_s & r_clk_d;
    assign cs_n_s    = r_cs_s;
    assign data_s    = r_dat_s;

endmodule

// File: rtl/qspi_psram_responder.sv
// Device-side QSPI PSRAM model: decodes quad read/write frames from
// the oversampled bus and serves a small internal byte memory.
module qspi_psram_responder
    import qspi_resp_pkg::*;
#(
    parameter int MEM_BYTES  = 256,
    parameter int DUMMY_BASE = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         qspi_clk_in,
    input  logic                         qspi_cs_n_in,
    input  logic [3:0]                   qspi_data_in,
    output logic [3:0]                   qspi_data_out,
    output logic [3:0]                   qspi_data_oe,
    input  logic [2:0]                   latency_cfg,
    input  logic                         load_en,
    input  logic [$clog2(MEM_BYTES)-1:0] load_addr,
    input  logic [7:0]                   load_data,
    output logic                         busy
);

    localparam int AW = $clog2(MEM_BYTES);

    logic             w_rise;
    logic             w_fall;
    logic             w_cs_n;
    logic [3:0]       w_data;
    logic             w_start;
    logic [7:0]       w_cmd_nxt;
    logic             w_cnt_st;
    logic             w_fe_we;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [7:0]       w_wdata;
    state_t           w_state_nxt;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_dummy;
    logic [7:0]       r_cmd;
    logic [AW-1:0]    r_addr;
    logic             r_half;
    logic [3:0]       r_wnib;
    logic [3:0]       r_dout;
    logic             r_oe;
    logic             r_armed;
    logic [7:0]       r_mem [MEM_BYTES];

    qspi_resp_sync u_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .qspi_clk_in  (qspi_clk_in),
        .qspi_cs_n_in (qspi_cs_n_in),
        .qspi_data_in (qspi_data_in),
        .sclk_rise    (w_rise),
        .sclk_fall    (w_fall),
        .cs_n_s       (w_cs_n),
        .data_s       (w_data)
    );

    // A frame needs CS seen high since the last start or reset.
    assign w_start   = (r_state == IDLE) && !w_cs_n && r_armed;
    assign w_cmd_nxt = {r_cmd[3:0], w_data};
    assign w_cnt_st  = (r_state == CMD) || (r_state == ADDR) ||
                       (r_state == DUMMY);

    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_n) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (r_armed) w_state_nxt = CMD;
                end
                CMD: begin
                    if (w_rise && r_cnt == CNT_W'(1)) begin
                        if (w_cmd_nxt == CMD_READ ||
                            w_cmd_nxt == CMD_WRITE)
                            w_state_nxt = ADDR;
                        else
                            w_state_nxt = IGNORE;
                    end
                end
                ADDR: begin
                    if (w_rise && r_cnt == CNT_W'(ADDR_NIBS - 1)) begin
                        if (r_cmd == CMD_WRITE)
                            w_state_nxt = WRITE;
                        else if (r_dummy != '0)
                            w_state_nxt = DUMMY;
                        else
                            w_state_nxt = READ;
                    end
                end
                DUMMY: begin
                    if (w_rise && r_cnt == r_dummy - CNT_W'(1))
                        w_state_nxt = READ;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_dummy <= '0;
            r_cmd   <= 8'h00;
            r_addr  <= '0;
            r_half  <= 1'b0;
            r_wnib  <= 4'h0;
            r_dout  <= 4'h0;
            r_oe    <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            if (w_cs_n)       r_armed <= 1'b1;
            else if (w_start) r_armed <= 1'b0;

            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if (w_rise && w_cnt_st)
                r_cnt <= r_cnt + CNT_W'(1);

            if (w_start) begin
                r_dummy <= CNT_W'(DUMMY_BASE) + CNT_W'(latency_cfg);
                r_half  <= 1'b0;
            end

            if (w_cs_n) begin
                r_oe   <= 1'b0;
                r_dout <= 4'h0;
                r_half <= 1'b0;
            end else begin
                unique case (r_state)
                    CMD: begin
                        if (w_rise) r_cmd <= w_cmd_nxt;
                    end
                    ADDR: begin
                        if (w_rise) r_addr <= {r_addr[AW-5:0], w_data};
                    end
                    READ: begin
                        if (w_fall) begin
                            r_oe   <= 1'b1;
                            r_half <= ~r_half;
                            if (r_half) begin
                                r_dout <= r_mem[r_addr][3:0];
                                r_addr <= r_addr + AW'(1);
                            end else begin
                                r_dout <= r_mem[r_addr][7:4];
                            end
                        end
                    end
                    WRITE: begin
                        if (w_rise) begin
                            r_half <= ~r_half;
                            if (r_half) r_addr <= r_addr + AW'(1);
                            else        r_wnib <= w_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Frame writes and backdoor loads are exclusive by state.
    assign w_fe_we = (r_state == WRITE) && !w_cs_n && w_rise && r_half;
    assign w_we    = w_fe_we ||
                     ((r_state == IDLE) && w_cs_n && load_en);
    assign w_waddr = w_fe_we ? r_addr : load_addr;
    assign w_wdata = w_fe_we ? {r_wnib, w_data} : load_data;

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    assign qspi_data_out = r_dout;
    assign qspi_data_oe  = {4{r_oe}};
    assign busy          = (r_state != IDLE);

endmodule
